// File: rtl/vga_pkg.sv
// Shared geometry, pixel type and state encoding for the scanline buffer.
// Also holds the RGB565 to RGB888 widening used at the output.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_LAST   = H_ACTIVE - 10'd1;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;

    typedef logic [15:0] pixel565_t;

    localparam pixel565_t BG_COLOR = 16'h0000;

    typedef enum logic {
        INIT,
        RUN
    } lb_state_t;

    // Widen each channel by replicating its top bits so full-scale maps to 8'hFF.
    function automatic logic [23:0] rgb565_to_888(input pixel565_t p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/line_ram.sv
// One scanline of RGB565 storage: a write port plus a registered read port.
// The read data appears one cycle after the read enable.
module line_ram
    import vga_pkg::*;
(
    input  logic      clk,
    input  logic      we,
    input  logic [9:0] waddr,
    input  pixel565_t wdata,
    input  logic      re,
    input  logic [9:0] raddr,
    output pixel565_t rdata
);

    pixel565_t mem [H_ACTIVE];
    pixel565_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/linebuf_scanout.sv
// Ping-pong scanline buffer: the sprite engine draws one bank while the other
// is scanned out and cleared behind the beam; the banks swap at end of line.
module linebuf_scanout
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        pix_en,
    input  logic [9:0]  sprite_pixel_col,
    input  logic [15:0] sprite_pixel_data,
    input  logic        wren_pixel_draw,
    input  logic        sprite_done,
    output logic        sprite_start,
    output logic [9:0]  draw_vcount,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        init_done,
    output logic [7:0]  overrun_cnt
);

    lb_state_t   state_q, state_d;
    logic [9:0]  clr_addr_q, clr_addr_d;
    logic        sel_q, sel_d;
    logic        drawing_q, drawing_d;
    logic        rd_pend_q, rd_pend_d;
    logic [9:0]  rd_addr_q, rd_addr_d;
    logic        rd_bank_q, rd_bank_d;
    logic [23:0] pixel_rgb_q, pixel_rgb_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        sprite_start_q, sprite_start_d;
    logic [9:0]  draw_vcount_q, draw_vcount_d;
    logic [7:0]  overrun_q, overrun_d;
    logic        init_done_q, init_done_d;

    logic        rd_issue;
    logic        swap;
    logic        draw_ok;
    logic [9:0]  next_line;
    pixel565_t   rd_data;

    logic [1:0]  bank_we;
    logic [1:0]  bank_re;
    logic [9:0]  bank_waddr [2];
    pixel565_t   bank_wdata [2];
    pixel565_t   bank_rdata [2];

    assign rd_issue  = (state_q == RUN) && pix_en && (hcount < H_ACTIVE);
    assign swap      = (state_q == RUN) && pix_en && (hcount == H_ACTIVE);
    assign draw_ok   = (state_q == RUN) && drawing_q && wren_pixel_draw
                       && (sprite_pixel_col < H_ACTIVE);
    assign next_line = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    assign rd_data   = rd_bank_q ? bank_rdata[1] : bank_rdata[0];

    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        sel_d          = sel_q;
        drawing_d      = drawing_q;
        rd_pend_d      = 1'b0;
        rd_addr_d      = rd_addr_q;
        rd_bank_d      = rd_bank_q;
        pixel_rgb_d    = pixel_rgb_q;
        pixel_valid_d  = 1'b0;
        sprite_start_d = 1'b0;
        draw_vcount_d  = draw_vcount_q;
        overrun_d      = overrun_q;
        init_done_d    = init_done_q;

        case (state_q)
            INIT: begin
                clr_addr_d = clr_addr_q + 10'd1;
                if (clr_addr_q == H_LAST) begin
                    clr_addr_d  = 10'd0;
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (rd_pend_q) begin
                    pixel_rgb_d   = rgb565_to_888(rd_data);
                    pixel_valid_d = 1'b1;
                end
                if (rd_issue) begin
                    rd_pend_d = 1'b1;
                    rd_addr_d = hcount;
                    rd_bank_d = sel_q;
                end
                if (sprite_done) begin
                    drawing_d = 1'b0;
                end
                // A done arriving with the swap still counts the line as finished.
                if (swap) begin
                    if (drawing_q && !sprite_done && overrun_q != 8'hFF) begin
                        overrun_d = overrun_q + 8'd1;
                    end
                    sel_d     = ~sel_q;
                    drawing_d = 1'b0;
                    if (next_line < V_ACTIVE) begin
                        draw_vcount_d  = next_line;
                        sprite_start_d = 1'b1;
                        drawing_d      = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // The clear-behind-read targets the bank captured at read time; the draw
    // bank is always the other one, so the two never collide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = clr_addr_q;
            bank_wdata[b] = BG_COLOR;
            bank_re[b]    = rd_issue && (sel_q == b[0]);
            if (state_q == INIT) begin
                bank_we[b] = 1'b1;
            end else if (rd_pend_q && (rd_bank_q == b[0])) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = rd_addr_q;
            end else if (draw_ok && (sel_q != b[0])) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = sprite_pixel_col;
                bank_wdata[b] = sprite_pixel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= INIT;
            clr_addr_q     <= 10'd0;
            sel_q          <= 1'b0;
            drawing_q      <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_addr_q      <= 10'd0;
            rd_bank_q      <= 1'b0;
            pixel_rgb_q    <= 24'd0;
            pixel_valid_q  <= 1'b0;
            sprite_start_q <= 1'b0;
            draw_vcount_q  <= 10'd0;
            overrun_q      <= 8'd0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            sel_q          <= sel_d;
            drawing_q      <= drawing_d;
            rd_pend_q      <= rd_pend_d;
            rd_addr_q      <= rd_addr_d;
            rd_bank_q      <= rd_bank_d;
            pixel_rgb_q    <= pixel_rgb_d;
            pixel_valid_q  <= pixel_valid_d;
            sprite_start_q <= sprite_start_d;
            draw_vcount_q  <= draw_vcount_d;
            overrun_q      <= overrun_d;
            init_done_q    <= init_done_d;
        end
    end

    line_ram u_bank0 (
        .clk   (clk),
        .we    (bank_we[0]),
        .waddr (bank_waddr[0]),
        .wdata (bank_wdata[0]),
        .re    (bank_re[0]),
        .raddr (hcount),
        .rdata (bank_rdata[0])
    );

    line_ram u_bank1 (
        .clk   (clk),
        .we    (bank_we[1]),
        .waddr (bank_waddr[1]),
        .wdata (bank_wdata[1]),
        .re    (bank_re[1]),
        .raddr (hcount),
        .rdata (bank_rdata[1])
    );

    assign sprite_start = sprite_start_q;
    assign draw_vcount  = draw_vcount_q;
    assign pixel_rgb    = pixel_rgb_q;
    assign pixel_valid  = pixel_valid_q;
    assign init_done    = init_done_q;
    assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_linebuf_scanout.sv
// Scoreboard bench for linebuf_scanout: scan strobes queue the expected pixel
// and its arrival cycle; a negedge monitor pops and compares each pixel_valid.
module tb_linebuf_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        pix_en;
    logic [9:0]  sprite_pixel_col;
    logic [15:0] sprite_pixel_data;
    logic        wren_pixel_draw;
    logic        sprite_done;
    logic        sprite_start;
    logic [9:0]  draw_vcount;
    logic [23:0] pixel_rgb;
    logic        pixel_valid;
    logic        init_done;
    logic [7:0]  overrun_cnt;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_col [4];
    logic [23:0] exp_rgb [4];

    linebuf_scanout dut (
        .clk               (clk),
        .reset             (reset),
        .hcount            (hcount),
        .vcount            (vcount),
        .pix_en            (pix_en),
        .sprite_pixel_col  (sprite_pixel_col),
        .sprite_pixel_data (sprite_pixel_data),
        .wren_pixel_draw   (wren_pixel_draw),
        .sprite_done       (sprite_done),
        .sprite_start      (sprite_start),
        .draw_vcount       (draw_vcount),
        .pixel_rgb         (pixel_rgb),
        .pixel_valid       (pixel_valid),
        .init_done         (init_done),
        .overrun_cnt       (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pixel_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pixel: got rgb=%06h at cycle %0d, required no pixel", pixel_rgb, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pixel_rgb !== e.rgb || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL pixel: got rgb=%06h at cycle %0d, required rgb=%06h at cycle %0d",
                             pixel_rgb, cyc, e.rgb, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) begin
            exp_col[i] = -1;
            exp_rgb[i] = 24'h000000;
        end
    endtask

    function automatic logic [23:0] expected_at(input int h);
        logic [23:0] v;
        v = 24'h000000;
        for (int i = 0; i < 4; i++) begin
            if (exp_col[i] == h) v = exp_rgb[i];
        end
        return v;
    endfunction

    task automatic strobe_pixel(input int h);
        exp_t e;
        hcount = h[9:0];
        pix_en = 1'b1;
        if (h < 640) begin
            e.rgb = expected_at(h);
            e.due = cyc + 2;
            sb.push_back(e);
        end
        tick();
        pix_en = 1'b0;
        tick();
    endtask

    task automatic scan_cols(input int last);
        for (int h = 0; h <= last; h++) begin
            strobe_pixel(h);
        end
    endtask

    task automatic apply_stimulus_draw(input int col, input logic [15:0] data, input logic done);
        sprite_pixel_col  = col[9:0];
        sprite_pixel_data = data;
        wren_pixel_draw   = 1'b1;
        sprite_done       = done;
        tick();
        wren_pixel_draw   = 1'b0;
        sprite_done       = 1'b0;
    endtask

    task automatic apply_stimulus_done();
        sprite_done = 1'b1;
        tick();
        sprite_done = 1'b0;
    endtask

    task automatic apply_stimulus_swap(input string tag, input int v, input logic done,
                                       input logic exp_start, input int exp_dv, input int exp_ovr);
        hcount      = 10'd640;
        vcount      = v[9:0];
        pix_en      = 1'b1;
        sprite_done = done;
        tick();
        pix_en      = 1'b0;
        sprite_done = 1'b0;
        check_output({tag, "_start"}, 32'(sprite_start), 32'(exp_start));
        check_output({tag, "_draw_vcount"}, 32'(draw_vcount), exp_dv);
        check_output({tag, "_overrun"}, 32'(overrun_cnt), exp_ovr);
        tick();
        check_output({tag, "_start_drop"}, 32'(sprite_start), 32'd0);
    endtask

    initial begin
        reset             = 1'b0;
        hcount            = 10'd0;
        vcount            = 10'd0;
        pix_en            = 1'b0;
        sprite_pixel_col  = 10'd0;
        sprite_pixel_data = 16'h0000;
        wren_pixel_draw   = 1'b0;
        sprite_done       = 1'b0;
        clear_exp();

        repeat (3) tick();
        check_output("rst_sprite_start", 32'(sprite_start), 32'd0);
        check_output("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_output("rst_init_done", 32'(init_done), 32'd0);
        check_output("rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        check_output("rst_draw_vcount", 32'(draw_vcount), 32'd0);
        check_output("rst_overrun", 32'(overrun_cnt), 32'd0);

        reset = 1'b1;
        repeat (639) tick();
        check_output("init_done_early", 32'(init_done), 32'd0);
        tick();
        check_output("init_done_rise", 32'(init_done), 32'd1);

        // Line 0: nothing drawn, and a strobe past the active area reads nothing.
        scan_cols(639);
        strobe_pixel(700);
        apply_stimulus_swap("swap_v4", 4, 1'b0, 1'b1, 5, 0);

        apply_stimulus_draw(10, 16'hF800, 1'b0);
        apply_stimulus_draw(640, 16'h07E0, 1'b0);
        apply_stimulus_draw(639, 16'h001F, 1'b0);
        apply_stimulus_draw(20, 16'h8410, 1'b1);
        apply_stimulus_swap("swap_v5", 5, 1'b0, 1'b1, 6, 0);
        apply_stimulus_done();
        apply_stimulus_draw(50, 16'h07E0, 1'b0);

        exp_col[0] = 10;  exp_rgb[0] = 24'hFF0000;
        exp_col[1] = 20;  exp_rgb[1] = 24'h848284;
        exp_col[2] = 639; exp_rgb[2] = 24'h0000FF;
        scan_cols(639);

        // Same bank again: everything must have been cleared by the first scan.
        apply_stimulus_swap("swap_v6", 6, 1'b0, 1'b1, 7, 0);
        apply_stimulus_done();
        apply_stimulus_swap("swap_v7", 7, 1'b0, 1'b1, 8, 0);
        clear_exp();
        scan_cols(639);

        apply_stimulus_draw(30, 16'hF800, 1'b0);
        apply_stimulus_swap("swap_v479", 479, 1'b0, 1'b0, 8, 1);
        apply_stimulus_draw(40, 16'hF800, 1'b0);
        exp_col[0] = 30; exp_rgb[0] = 24'hFF0000;
        scan_cols(639);

        apply_stimulus_swap("swap_v524", 524, 1'b0, 1'b1, 0, 1);
        apply_stimulus_swap("swap_done_same", 0, 1'b1, 1'b1, 1, 1);

        for (int i = 0; i < 260; i++) begin
            hcount = 10'd640;
            vcount = 10'd10;
            pix_en = 1'b1;
            tick();
            pix_en = 1'b0;
            tick();
        end
        check_output("overrun_saturate", 32'(overrun_cnt), 32'd255);
        check_output("sat_draw_vcount", 32'(draw_vcount), 32'd11);

        clear_exp();
        scan_cols(299);
        hcount = 10'd300;
        pix_en = 1'b1;
        reset  = 1'b0;
        #1;
        check_output("mid_rst_sprite_start", 32'(sprite_start), 32'd0);
        check_output("mid_rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_output("mid_rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        check_output("mid_rst_init_done", 32'(init_done), 32'd0);
        check_output("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
        check_output("mid_rst_draw_vcount", 32'(draw_vcount), 32'd0);
        tick();
        pix_en = 1'b0;
        tick();

        // Strobes during the second INIT must not produce pixels.
        reset  = 1'b1;
        hcount = 10'd5;
        for (int i = 0; i < 639; i++) begin
            pix_en = (i % 2 == 1);
            tick();
        end
        pix_en = 1'b0;
        check_output("reinit_done_early", 32'(init_done), 32'd0);
        tick();
        check_output("reinit_done_rise", 32'(init_done), 32'd1);

        scan_cols(15);
        apply_stimulus_swap("swap_after_rst", 2, 1'b0, 1'b1, 3, 0);

        repeat (4) tick();
        check_output("scoreboard_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
